eae_sequencer: RTL and testbench

Sequencer for the extended arithmetic element. Accepts one EAE operation at a time from the CPU control path (MUY, DVI or SWP), latches its operands, and pulses the shared start strobe for the multiply or divide datapath. It waits for the matching finish flag, captures the result, and returns AC, MQ and link with a one-cycle done pulse. DVI overflow and SWP are resolved locally without starting the datapath.

---
 rtl/eae_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_eae_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eae_sequencer.sv
// Purpose : EAE sequencer. Runs one MUY/DVI/SWP at a time and starts the mul/div datapath.
// Latency : local ops (SWP, DVI overflow, reserved) give done 2 cycles after the request edge.
//           Datapath ops give done 1 cycle after the finish flag is seen in WAIT.
// Backpressure: there is no queue. req is sampled only while idle (busy low).
//               A request raised while busy is dropped, not held.
// Ports   : clock/reset (sync, active-high); req/op/ac_in/mq_in/operand_in (request and operands);
//           busy/done/ac_out/mq_out/link_out/err (status and held result);
//           eae_start/mul_fin/mul_product/div_fin/div_quot/div_rem/div_link (datapath handshake).
// Config  : define EAE_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles with err=1.
//           The default build waits indefinitely.
module eae_sequencer
`ifdef EAE_TIMEOUT_EN
#(
   parameter int TIMEOUT_CYCLES = 31
)
`endif
(
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic [1:0]  op,
   input  logic [11:0] ac_in,
   input  logic [11:0] mq_in,
   input  logic [11:0] operand_in,
   output logic        busy,
   output logic        done,
   output logic [11:0] ac_out,
   output logic [11:0] mq_out,
   output logic        link_out,
   output logic        err,
   output logic        eae_start,
   input  logic        mul_fin,
   input  logic [23:0] mul_product,
   input  logic        div_fin,
   input  logic [11:0] div_quot,
   input  logic [11:0] div_rem,
   input  logic        div_link
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      WAIT     = 2'd2,
      WRITE    = 2'd3
   } state_t;

   localparam logic [1:0] OP_MUY = 2'b00;
   localparam logic [1:0] OP_DVI = 2'b01;
   localparam logic [1:0] OP_SWP = 2'b10;

   state_t      state, state_nxt;
   logic [1:0]  op_q;
   logic [11:0] ac_q, mq_q, opnd_q;

   // Result bus computed in DISPATCH/WAIT and loaded into the output
   // registers on the way into WRITE, so outputs change exactly with done.
   logic        load_res;
   logic [11:0] res_ac, res_mq;
   logic        res_link, res_err;
   logic        start;

`ifdef EAE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout;

   // Counter sits at zero outside WAIT, so it is clear on every WAIT entry.
   // It reaches TIMEOUT_CYCLES-1 during the last permitted WAIT cycle.
   assign timeout = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset || state != WAIT) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      load_res  = 1'b0;
      res_ac    = ac_q;
      res_mq    = mq_q;
      res_link  = 1'b0;
      res_err   = 1'b0;
      start     = 1'b0;
      case (state)
         IDLE: begin
            if (req) state_nxt = DISPATCH;
         end
         DISPATCH: begin
            case (op_q)
               OP_MUY: begin
                  start     = 1'b1;
                  state_nxt = WAIT;
               end
               OP_DVI: begin
                  // A quotient that would not fit in 12 bits (including divide by zero)
                  // is flagged as overflow here and never reaches the divider.
                  if (ac_q >= opnd_q) begin
                     load_res  = 1'b1;
                     res_link  = 1'b1;
                     state_nxt = WRITE;
                  end else begin
                     start     = 1'b1;
                     state_nxt = WAIT;
                  end
               end
               OP_SWP: begin
                  load_res  = 1'b1;
                  res_ac    = mq_q;
                  res_mq    = ac_q;
                  state_nxt = WRITE;
               end
               default: begin
                  load_res  = 1'b1;
                  res_err   = 1'b1;
                  state_nxt = WRITE;
               end
            endcase
         end
         WAIT: begin
            // Only the finish flag of the unit actually started is honoured.
            if (op_q == OP_MUY && mul_fin) begin
               load_res  = 1'b1;
               res_ac    = mul_product[23:12];
               res_mq    = mul_product[11:0];
               state_nxt = WRITE;
            end else if (op_q == OP_DVI && div_fin) begin
               load_res  = 1'b1;
               res_ac    = div_rem;
               res_mq    = div_quot;
               res_link  = div_link;
               state_nxt = WRITE;
            end
`ifdef EAE_TIMEOUT_EN
            else if (timeout) begin
               load_res  = 1'b1;
               res_err   = 1'b1;
               state_nxt = WRITE;
            end
`endif
         end
         WRITE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= '0;
         ac_q     <= '0;
         mq_q     <= '0;
         opnd_q   <= '0;
         ac_out   <= '0;
         mq_out   <= '0;
         link_out <= 1'b0;
         err      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req) begin
            op_q   <= op;
            ac_q   <= ac_in;
            mq_q   <= mq_in;
            opnd_q <= operand_in;
         end
         if (load_res) begin
            ac_out   <= res_ac;
            mq_out   <= res_mq;
            link_out <= res_link;
            err      <= res_err;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == WRITE);
   assign eae_start = start;

endmodule

// File: tb/tb_eae_sequencer.sv
// Purpose : bench for eae_sequencer. Random and directed EAE operations are checked
//           against a reference model of the EAE rules.
// Latency : n/a (bench). Done-cycle timing is checked for every operation.
// Backpressure: req is held high through some operations to show it is ignored while busy.
module tb_eae_sequencer;

   localparam logic [1:0] MUY = 2'b00;
   localparam logic [1:0] DVI = 2'b01;
   localparam logic [1:0] SWP = 2'b10;
   localparam logic [1:0] RSV = 2'b11;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [11:0] ac_in = '0, mq_in = '0, operand_in = '0;
   logic        busy, done, link_out, err, eae_start;
   logic [11:0] ac_out, mq_out;
   logic        mul_fin = 1'b0, div_fin = 1'b0, div_link = 1'b0;
   logic [23:0] mul_product = '0;
   logic [11:0] div_quot = '0, div_rem = '0;

   int n_cmp = 0;
   int n_fail = 0;

   eae_sequencer dut (
      .clock(clock), .reset(reset), .req(req), .op(op),
      .ac_in(ac_in), .mq_in(mq_in), .operand_in(operand_in),
      .busy(busy), .done(done), .ac_out(ac_out), .mq_out(mq_out),
      .link_out(link_out), .err(err), .eae_start(eae_start),
      .mul_fin(mul_fin), .mul_product(mul_product),
      .div_fin(div_fin), .div_quot(div_quot), .div_rem(div_rem), .div_link(div_link)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Expected {ac, mq, link, err} from the EAE rules. The datapath returns
   // AC + MQ*MB for MUY and {AC,MQ}/MB for DVI.
   function automatic logic [25:0] ref_expect(input logic [1:0] o, input logic [11:0] a, m, b,
                                              input logic dl);
      logic [23:0] p, dvd;
      p   = 24'(a) + 24'(m) * 24'(b);
      dvd = {a, m};
      case (o)
         MUY: return {p, 2'b00};
         DVI: begin
            if (a >= b) return {a, m, 2'b10};
            return {12'(dvd % 24'(b)), 12'(dvd / 24'(b)), dl, 1'b0};
         end
         SWP: return {m, a, 2'b00};
         default: return {a, m, 2'b01};
      endcase
   endfunction

   function automatic bit ref_local(input logic [1:0] o, input logic [11:0] a, b);
      return (o == SWP) || (o == RSV) || (o == DVI && a >= b);
   endfunction

   // Issues one request at the current negedge and plays the datapath.
   // The datapath raises its finish flag d cycles after eae_start.
   // Outputs: cycle of the first eae_start, number of starts, done cycle,
   // number of dones and busy violations (cycle 1 is DISPATCH).
   task automatic do_op(input logic [1:0] o_op, input logic [11:0] a, m, b, input int d,
                        input logic dl, input bit spur, input bit hold, input int limit,
                        output int s_cyc, output int n_start, output int d_cyc,
                        output int n_done, output int busy_bad, output logic [25:0] res);
      logic [23:0] prod;
      logic [11:0] q, r;
      prod = 24'(a) + 24'(m) * 24'(b);
      q = (b != 0) ? 12'({a, m} / 24'(b)) : 12'd0;
      r = (b != 0) ? 12'({a, m} % 24'(b)) : 12'd0;
      s_cyc = -1; n_start = 0; d_cyc = -1; n_done = 0; busy_bad = 0; res = 'x;
      req = 1'b1; op = o_op; ac_in = a; mq_in = m; operand_in = b;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clock);
         if (!hold) req = 1'b0;
         op = 2'($urandom); ac_in = 12'($urandom); mq_in = 12'($urandom);
         operand_in = 12'($urandom);
         mul_fin = 1'b0; div_fin = 1'b0;
         mul_product = 24'($urandom); div_quot = 12'($urandom);
         div_rem = 12'($urandom); div_link = 1'($urandom);
         if (eae_start === 1'b1) begin
            n_start++;
            if (s_cyc < 0) s_cyc = k;
         end
         if (busy !== 1'b1) busy_bad++;
         if (done === 1'b1) begin
            n_done++;
            d_cyc = k;
            res = {ac_out, mq_out, link_out, err};
            break;
         end
         if (spur) begin
            if (o_op == MUY) div_fin = 1'($urandom);
            else mul_fin = 1'($urandom);
            if (s_cyc == k) begin
               if (o_op == MUY) mul_fin = 1'b1;
               else div_fin = 1'b1;
            end
         end
         if (s_cyc > 0 && k == s_cyc + d) begin
            if (o_op == MUY) begin
               mul_fin = 1'b1; mul_product = prod;
            end else begin
               div_fin = 1'b1; div_quot = q; div_rem = r; div_link = dl;
            end
         end
      end
      if (d_cyc > 0) begin
         @(negedge clock);
         req = 1'b0; mul_fin = 1'b0; div_fin = 1'b0;
         if (busy !== 1'b0 || done !== 1'b0 || eae_start !== 1'b0) busy_bad++;
      end
      mul_fin = 1'b0; div_fin = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_cmp++;
      if ({busy, done, eae_start, ac_out, mq_out, link_out, err} !== 28'd0) begin
         n_fail++;
         $display("FAIL reset_values: got %h want 0", {busy, done, eae_start, ac_out, mq_out, link_out, err});
      end
      reset = 1'b0;
      @(negedge clock);
      n_cmp++;
      if ({busy, done, eae_start} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got busy/done/start %b want 000", {busy, done, eae_start});
      end
   endtask

   task automatic test_muy();
      int s, ns, dc, nd, bb, d;
      logic [25:0] res, exp;
      logic [11:0] a, m, b;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            a = 12'o0000; m = 12'o0012; b = 12'o0005; d = 12;
         end else begin
            a = 12'($urandom); m = 12'($urandom); b = 12'($urandom); d = $urandom_range(1, 20);
         end
         exp = ref_expect(MUY, a, m, b, 1'b0);
         do_op(MUY, a, m, b, d, 1'b0, (i % 2) == 1, (i % 3) == 1, 60, s, ns, dc, nd, bb, res);
         n_cmp++;
         if (s !== 1 || ns !== 1 || dc !== d + 2 || nd !== 1 || bb !== 0) begin
            n_fail++;
            $display("FAIL muy_timing[%0d]: got start@%0d x%0d done@%0d x%0d busy_err %0d, want start@1 x1 done@%0d x1 busy_err 0",
                     i, s, ns, dc, nd, bb, d + 2);
         end
         n_cmp++;
         if (res !== exp) begin
            n_fail++;
            $display("FAIL muy_result[%0d]: got %h want %h", i, res, exp);
         end
         n_cmp++;
         if ({ac_out, mq_out, link_out, err} !== exp) begin
            n_fail++;
            $display("FAIL muy_hold[%0d]: got %h want %h", i, {ac_out, mq_out, link_out, err}, exp);
         end
      end
   endtask

   task automatic test_dvi();
      int s, ns, dc, nd, bb, d;
      logic [25:0] res, exp;
      logic [11:0] a, m, b;
      logic dl;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) begin
            a = 12'o0000; m = 12'o0144; b = 12'o0007; d = 5; dl = 1'b0;
         end else begin
            b = 12'($urandom_range(1, 4095)); a = 12'($urandom_range(0, int'(b) - 1));
            m = 12'($urandom); d = $urandom_range(1, 20); dl = 1'($urandom);
         end
         exp = ref_expect(DVI, a, m, b, dl);
         do_op(DVI, a, m, b, d, dl, (i % 2) == 0, (i % 3) == 2, 60, s, ns, dc, nd, bb, res);
         n_cmp++;
         if (s !== 1 || ns !== 1 || dc !== d + 2 || nd !== 1 || bb !== 0) begin
            n_fail++;
            $display("FAIL dvi_timing[%0d]: got start@%0d x%0d done@%0d x%0d busy_err %0d, want start@1 x1 done@%0d x1 busy_err 0",
                     i, s, ns, dc, nd, bb, d + 2);
         end
         n_cmp++;
         if (res !== exp) begin
            n_fail++;
            $display("FAIL dvi_result[%0d]: got %h want %h", i, res, exp);
         end
      end
   endtask

   task automatic test_dvi_overflow();
      int s, ns, dc, nd, bb;
      logic [25:0] res, exp;
      logic [11:0] a, m, b;
      for (int i = 0; i < 6; i++) begin
         m = 12'($urandom);
         if (i == 0) begin a = 12'o0010; b = 12'o0005; end
         else if (i == 1) begin a = 12'o0010; b = 12'o0000; end
         else if (i == 2) begin a = 12'($urandom); b = a; end
         else begin a = 12'($urandom_range(1, 4095)); b = 12'($urandom_range(0, int'(a))); end
         exp = ref_expect(DVI, a, m, b, 1'b0);
         do_op(DVI, a, m, b, 3, 1'b0, 1'b1, (i % 2) == 1, 40, s, ns, dc, nd, bb, res);
         n_cmp++;
         if (ns !== 0 || dc !== 2 || nd !== 1 || bb !== 0) begin
            n_fail++;
            $display("FAIL dvi_ovf_timing[%0d]: got starts %0d done@%0d x%0d busy_err %0d, want starts 0 done@2 x1 busy_err 0",
                     i, ns, dc, nd, bb);
         end
         n_cmp++;
         if (res !== exp) begin
            n_fail++;
            $display("FAIL dvi_ovf_result[%0d]: got %h want %h", i, res, exp);
         end
      end
   endtask

   task automatic test_swp();
      int s, ns, dc, nd, bb;
      logic [25:0] res, exp;
      logic [11:0] a, m;
      for (int i = 0; i < 5; i++) begin
         if (i == 0) begin a = 12'o1234; m = 12'o4321; end
         else begin a = 12'($urandom); m = 12'($urandom); end
         exp = ref_expect(SWP, a, m, 12'd0, 1'b0);
         do_op(SWP, a, m, 12'($urandom), 2, 1'b0, 1'b1, (i % 2) == 0, 40, s, ns, dc, nd, bb, res);
         n_cmp++;
         if (ns !== 0 || dc !== 2 || nd !== 1 || bb !== 0) begin
            n_fail++;
            $display("FAIL swp_timing[%0d]: got starts %0d done@%0d x%0d busy_err %0d, want starts 0 done@2 x1 busy_err 0",
                     i, ns, dc, nd, bb);
         end
         n_cmp++;
         if (res !== exp) begin
            n_fail++;
            $display("FAIL swp_result[%0d]: got %h want %h", i, res, exp);
         end
      end
   endtask

   task automatic test_reserved();
      int s, ns, dc, nd, bb;
      logic [25:0] res, exp;
      logic [11:0] a, m;
      for (int i = 0; i < 3; i++) begin
         a = 12'($urandom); m = 12'($urandom);
         exp = ref_expect(RSV, a, m, 12'd0, 1'b0);
         do_op(RSV, a, m, 12'($urandom), 2, 1'b0, 1'b1, 1'b0, 40, s, ns, dc, nd, bb, res);
         n_cmp++;
         if (ns !== 0 || dc !== 2 || nd !== 1 || bb !== 0 || res !== exp) begin
            n_fail++;
            $display("FAIL reserved[%0d]: got starts %0d done@%0d res %h, want starts 0 done@2 res %h",
                     i, ns, dc, res, exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      int s, ns, dc, nd, bb, d, es, ed;
      logic [25:0] res, exp;
      logic [11:0] a, m, b;
      logic [1:0] o;
      logic dl;
      for (int i = 0; i < 12; i++) begin
         o = 2'($urandom); a = 12'($urandom); m = 12'($urandom); b = 12'($urandom);
         if (o == DVI && (i % 2) == 0) a = 12'($urandom_range(0, 15));
         d = $urandom_range(1, 20); dl = 1'($urandom);
         exp = ref_expect(o, a, m, b, dl);
         es = ref_local(o, a, b) ? 0 : 1;
         ed = ref_local(o, a, b) ? 2 : d + 2;
         do_op(o, a, m, b, d, dl, 1'b1, 1'b1, 60, s, ns, dc, nd, bb, res);
         n_cmp++;
         if (ns !== es || dc !== ed || nd !== 1 || bb !== 0 || res !== exp) begin
            n_fail++;
            $display("FAIL b2b[%0d] op %0d: got starts %0d done@%0d x%0d busy_err %0d res %h, want starts %0d done@%0d x1 busy_err 0 res %h",
                     i, o, ns, dc, nd, bb, res, es, ed, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      int s, ns, dc, nd, bb, bad;
      logic [25:0] res, exp;
      logic [11:0] a, m, b;
      a = 12'($urandom); m = 12'($urandom); b = 12'($urandom);
      do_op(MUY, a, m, b, 1000, 1'b0, 1'b0, 1'b0, 6, s, ns, dc, nd, bb, res);
      n_cmp++;
      if (ns !== 1 || nd !== 0 || bb !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_pre: got starts %0d dones %0d busy_err %0d, want 1 0 0", ns, nd, bb);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_cmp++;
      if ({busy, done, eae_start, ac_out, mq_out, link_out, err} !== 28'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got %h want 0", {busy, done, eae_start, ac_out, mq_out, link_out, err});
      end
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         mul_fin = 1'b1; mul_product = 24'($urandom);
         @(negedge clock);
         if (done !== 1'b0 || busy !== 1'b0 || ac_out !== 12'd0) bad++;
      end
      mul_fin = 1'b0;
      n_cmp++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_late_fin: got %0d bad cycles want 0", bad);
      end
      exp = ref_expect(MUY, a, m, b, 1'b0);
      do_op(MUY, a, m, b, 4, 1'b0, 1'b0, 1'b0, 40, s, ns, dc, nd, bb, res);
      n_cmp++;
      if (ns !== 1 || dc !== 6 || nd !== 1 || bb !== 0 || res !== exp) begin
         n_fail++;
         $display("FAIL rst_mid_recover: got starts %0d done@%0d res %h, want starts 1 done@6 res %h",
                  ns, dc, res, exp);
      end
   endtask

   task automatic test_timeout();
      int s, ns, dc, nd, bb;
      logic [25:0] res;
      logic [11:0] a, m, b;
      a = 12'($urandom_range(0, 100)); m = 12'($urandom); b = 12'($urandom_range(200, 4095));
`ifdef EAE_TIMEOUT_EN
      do_op(MUY, a, m, b, 1000, 1'b0, 1'b1, 1'b0, 60, s, ns, dc, nd, bb, res);
      n_cmp++;
      if (ns !== 1 || dc !== 33 || nd !== 1 || bb !== 0 || res !== {a, m, 2'b01}) begin
         n_fail++;
         $display("FAIL timeout_muy: got starts %0d done@%0d res %h, want starts 1 done@33 res %h",
                  ns, dc, res, {a, m, 2'b01});
      end
      do_op(DVI, a, m, b, 1000, 1'b0, 1'b1, 1'b0, 60, s, ns, dc, nd, bb, res);
      n_cmp++;
      if (ns !== 1 || dc !== 33 || nd !== 1 || bb !== 0 || res !== {a, m, 2'b01}) begin
         n_fail++;
         $display("FAIL timeout_dvi: got starts %0d done@%0d res %h, want starts 1 done@33 res %h",
                  ns, dc, res, {a, m, 2'b01});
      end
`else
      do_op(MUY, a, m, b, 1000, 1'b0, 1'b1, 1'b0, 80, s, ns, dc, nd, bb, res);
      n_cmp++;
      if (ns !== 1 || nd !== 0 || bb !== 0) begin
         n_fail++;
         $display("FAIL no_timeout: got starts %0d dones %0d busy_err %0d, want 1 0 0", ns, nd, bb);
      end
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_timeout_reset: got busy %b want 0", busy);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_muy();
      test_dvi();
      test_dvi_overflow();
      test_swp();
      test_reserved();
      test_back_to_back();
      test_reset_mid();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
